// File: rtl/morse_pkg.sv
// Shared encodings and thresholds for the Morse stream receive path.
package morse_pkg;

  // Two-bit symbol encodings packed into the character code, first symbol in the LSBs
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  // Duration thresholds in Morse units
  localparam int unsigned DASH_UNITS     = 2;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 7;

  localparam logic [3:0] UNITS_MAX = 4'd15;

  // Receiver states: released/empty, key down, released with partial character,
  // character emitted and waiting to see whether the silence becomes a word gap
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WORDWAIT = 2'd3
  } morse_state_e;

endpackage

// File: rtl/morse_token_fifo.sv
// First-word-fall-through token FIFO; a pop frees a slot for a push in the same cycle.
module morse_token_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign valid    = (count_q != '0);
  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign pop_data = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    pop_ok  = pop & valid;
    push_ok = push & (~full | pop_ok);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Morse key receiver: synchronise, debounce, time presses/gaps in units,
// assemble characters and queue them behind a valid/ready interface.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES     = 5_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned MAX_SYMBOLS     = 5,
  parameter int unsigned FIFO_DEPTH      = 4,
  localparam int unsigned CODE_W         = 2 * MAX_SYMBOLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_space,
  output logic              out_error,
  output logic              writing,
  output logic [3:0]        units,
  output logic              overflow
);

  localparam int unsigned CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_SYMBOLS + 1);
  localparam int unsigned TOK_W = CODE_W + 2;

  logic [1:0]        sync_q, sync_d;
  logic              key;
  logic              key_prev_q, key_prev_d;
  logic              key_rise, key_fall, key_edge;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [3:0]        units_q, units_d;
  morse_state_e      state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic              err_q, err_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        sym;
  logic              push;
  logic [TOK_W-1:0]  push_token;
  logic              fifo_full;
  logic              fifo_valid;
  logic [TOK_W-1:0]  head;

  // Two-flop synchroniser for the asynchronous key
  always_comb begin
    sync_d = {sync_q[0], button};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    assign key = sync_q[1];
  end else begin : g_debounce
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_q, key_d;

    // Accept the synchronised level only after a run of consecutive differing samples
    always_comb begin
      key_d    = key_q;
      db_cnt_d = '0;
      if (sync_q[1] != key_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_d = sync_q[1];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        key_q    <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        key_q    <= key_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    assign key = key_q;
  end

  assign key_rise = key & ~key_prev_q;
  assign key_fall = ~key & key_prev_q;
  assign key_edge = key ^ key_prev_q;

  // Unit timer: cycle prescaler plus saturating unit count, restarted on every key edge
  always_comb begin
    key_prev_d = key;
    cyc_d      = cyc_q;
    units_d    = units_q;
    if (key_edge) begin
      cyc_d   = '0;
      units_d = '0;
    end else if (cyc_q == CYC_W'(UNIT_CYCLES - 1)) begin
      cyc_d = '0;
      if (units_q != UNITS_MAX) begin
        units_d = units_q + 1'b1;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev_q <= 1'b0;
      cyc_q      <= '0;
      units_q    <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      cyc_q      <= cyc_d;
      units_q    <= units_d;
    end
  end

  // Character assembly FSM; a new press always wins over a gap threshold in the same cycle
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    sym_cnt_d  = sym_cnt_q;
    err_d      = err_q;
    push       = 1'b0;
    push_token = '0;
    sym        = (units_q < 4'(DASH_UNITS)) ? SYM_DOT : SYM_DASH;
    case (state_q)
      ST_IDLE: begin
        if (key_rise) begin
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (key_fall) begin
          state_d = ST_GAP;
          if (sym_cnt_q < CNT_W'(MAX_SYMBOLS)) begin
            for (int unsigned i = 0; i < MAX_SYMBOLS; i++) begin
              if (sym_cnt_q == CNT_W'(i)) begin
                code_d[2*i +: 2] = sym;
              end
            end
            sym_cnt_d = sym_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (key_rise) begin
          state_d = ST_PRESS;
        end else if (units_q >= 4'(CHAR_GAP_UNITS)) begin
          push       = 1'b1;
          push_token = {err_q, 1'b0, code_q};
          code_d     = '0;
          sym_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = ST_WORDWAIT;
        end
      end
      ST_WORDWAIT: begin
        if (key_rise) begin
          state_d = ST_PRESS;
        end else if (units_q >= 4'(WORD_GAP_UNITS)) begin
          push       = 1'b1;
          push_token = {1'b0, 1'b1, {CODE_W{1'b0}}};
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      sym_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      sym_cnt_q <= sym_cnt_d;
      err_q     <= err_d;
    end
  end

  // Sticky drop flag; a same-cycle pop makes room so a full FIFO does not drop
  always_comb begin
    overflow_d = overflow_q | (push & fifo_full & ~(out_ready & fifo_valid));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  morse_token_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_token),
    .full      (fifo_full),
    .pop       (out_ready),
    .pop_data  (head),
    .valid     (fifo_valid)
  );

  assign out_valid = fifo_valid;
  assign out_code  = fifo_valid ? head[CODE_W-1:0] : '0;
  assign out_space = fifo_valid & head[TOK_W-2];
  assign out_error = fifo_valid & head[TOK_W-1];
  assign writing   = (state_q == ST_PRESS) | ((state_q == ST_GAP) & (sym_cnt_q != '0));
  assign units     = units_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
module tb_morse_stream_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_space, out_error, writing, overflow;
  logic [9:0] out_code;
  logic [3:0] units;

  logic       button_db = 1'b0;
  logic       ready_db = 1'b0;
  logic       valid_db, space_db, error_db, writing_db, overflow_db;
  logic [9:0] code_db;
  logic [3:0] units_db;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_ready = 1'b0;

  // Popped tokens as {error, space, code}
  logic [11:0] got[$];

  always #5 clk = ~clk;

  morse_stream_decoder #(
    .UNIT_CYCLES     (4),
    .DEBOUNCE_CYCLES (0),
    .MAX_SYMBOLS     (5),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button    (button),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_space (out_space),
    .out_error (out_error),
    .writing   (writing),
    .units     (units),
    .overflow  (overflow)
  );

  morse_stream_decoder #(
    .UNIT_CYCLES     (4),
    .DEBOUNCE_CYCLES (8),
    .MAX_SYMBOLS     (5),
    .FIFO_DEPTH      (4)
  ) dut_db (
    .clk       (clk),
    .reset     (reset),
    .button    (button_db),
    .out_valid (valid_db),
    .out_ready (ready_db),
    .out_code  (code_db),
    .out_space (space_db),
    .out_error (error_db),
    .writing   (writing_db),
    .units     (units_db),
    .overflow  (overflow_db)
  );

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got.push_back({out_error, out_space, out_code});
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference token for a character written as a string of '.' and '-'
  function automatic logic [11:0] char_token(input string s);
    int unsigned acc = 0;
    int unsigned w = 1;
    for (int i = 0; i < s.len(); i++) begin
      if (i < 5) acc += ((s[i] == "-") ? 2 : 1) * w;
      w = w * 4;
    end
    return {(s.len() > 5) ? 1'b1 : 1'b0, 1'b0, 10'(acc)};
  endfunction

  localparam logic [11:0] SPACE_TOK = 12'h400;

  // Key one character; returns right after the final release
  task automatic send_char(input string s);
    for (int i = 0; i < s.len(); i++) begin
      button = 1'b1;
      if (s[i] == "-") tick(int'($urandom_range(12, 14)));
      else             tick(int'($urandom_range(4, 5)));
      button = 1'b0;
      if (i != s.len() - 1) tick(int'($urandom_range(4, 8)));
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(4);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (out_code !== 10'd0) begin n_fail++; $display("FAIL reset_code: got %h want 000", out_code); end
    reset = 1'b1;
    tick(2);
    n_tests++; if (writing !== 1'b0) begin n_fail++; $display("FAIL reset_writing: got %b want 0", writing); end
    n_tests++; if (units !== 4'd0) begin n_fail++; $display("FAIL reset_units: got %0d want 0", units); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if ({valid_db, units_db} !== 5'd0) begin n_fail++; $display("FAIL reset_db: got %h want 00", {valid_db, units_db}); end
  endtask

  task automatic test_single_e;
    got.delete();
    out_ready = 1'b1;
    send_char(".");
    tick(18);
    n_tests++; if (got.size() != 1) begin n_fail++; $display("FAIL e_count: got %0d want 1", got.size()); end
    else if (got[0] !== char_token(".")) begin n_fail++; $display("FAIL e_token: got %h want %h", got[0], char_token(".")); end
    tick(22);
    n_tests++; if (got.size() != 2) begin n_fail++; $display("FAIL e_space_count: got %0d want 2", got.size()); end
    else if (got[1] !== SPACE_TOK) begin n_fail++; $display("FAIL e_space: got %h want %h", got[1], SPACE_TOK); end
  endtask

  task automatic test_dash_dot;
    got.delete();
    send_char("-.-.");
    tick(40);
    n_tests++; if (got.size() != 2) begin n_fail++; $display("FAIL c_count: got %0d want 2", got.size()); end
    else begin
      if (got[0] !== 12'h066) begin n_fail++; $display("FAIL c_token: got %h want 066", got[0]); end
      n_tests++; if (got[1] !== SPACE_TOK) begin n_fail++; $display("FAIL c_space: got %h want %h", got[1], SPACE_TOK); end
    end
  endtask

  task automatic test_error;
    got.delete();
    send_char("......");
    tick(40);
    n_tests++; if (got.size() != 2) begin n_fail++; $display("FAIL err_count: got %0d want 2", got.size()); end
    else if (got[0] !== 12'h955) begin n_fail++; $display("FAIL err_token: got %h want 955", got[0]); end
  endtask

  task automatic test_hold;
    got.delete();
    button = 1'b1;
    tick(100);
    n_tests++; if (writing !== 1'b1) begin n_fail++; $display("FAIL hold_writing: got %b want 1", writing); end
    n_tests++; if (units !== 4'd15) begin n_fail++; $display("FAIL hold_units: got %0d want 15", units); end
    button = 1'b0;
    tick(40);
    n_tests++; if (got.size() != 2) begin n_fail++; $display("FAIL hold_count: got %0d want 2", got.size()); end
    else if (got[0] !== char_token("-")) begin n_fail++; $display("FAIL hold_token: got %h want %h", got[0], char_token("-")); end
  endtask

  task automatic test_random;
    logic [11:0] exp_q[$];
    string s;
    int nchars;
    got.delete();
    rand_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      nchars = int'($urandom_range(1, 3));
      for (int c = 0; c < nchars; c++) begin
        s = "";
        for (int k = int'($urandom_range(1, 6)); k > 0; k--) s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
        send_char(s);
        exp_q.push_back(char_token(s));
        if (c != nchars - 1) tick(int'($urandom_range(14, 20)));
        else begin
          tick(int'($urandom_range(32, 36)));
          exp_q.push_back(SPACE_TOK);
        end
      end
    end
    tick(20);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick(20);
    n_tests++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_token[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    bit seen = 1'b0;
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_char(".");
      tick(16);
    end
    send_char("-.");
    for (int c = 0; c < 60 && !seen; c++) begin
      if (writing === 1'b1 && units === 4'd3) seen = 1'b1;
      else tick(1);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL fpp_wait: got no gap threshold want one within 60 cycles"); end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(2);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    out_ready = 1'b1;
    tick(40);
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL fpp_count: got %0d want 6", got.size()); end
    else if (got[4] !== char_token("-.")) begin n_fail++; $display("FAIL fpp_token: got %h want %h", got[4], char_token("-.")); end
  endtask

  task automatic test_overflow;
    bit all_e = 1'b1;
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_char(".");
      tick(16);
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
    send_char(".");
    for (int i = 0; i < 3; i++) begin
      tick(6);
      n_tests++; if ({out_valid, out_error, out_space, out_code} !== 13'h1001) begin
        n_fail++; $display("FAIL ovf_head: got %h want 1001", {out_valid, out_error, out_space, out_code});
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    out_ready = 1'b1;
    tick(8);
    foreach (got[i]) if (got[i] !== 12'h001) all_e = 1'b0;
    n_tests++; if (got.size() != 4 || !all_e) begin n_fail++; $display("FAIL ovf_drain: got %0d entries (all E=%b) want 4 E", got.size(), all_e); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    tick(30);
  endtask

  task automatic test_reset_mid;
    got.delete();
    out_ready = 1'b1;
    button = 1'b1;
    tick(8);
    n_tests++; if (writing !== 1'b1) begin n_fail++; $display("FAIL mid_writing: got %b want 1", writing); end
    reset = 1'b0;
    tick(2);
    button = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    n_tests++; if ({writing, units, overflow, out_valid} !== 7'd0) begin
      n_fail++; $display("FAIL mid_state: got w=%b u=%0d o=%b v=%b want all 0", writing, units, overflow, out_valid);
    end
    tick(40);
    n_tests++; if (got.size() != 0) begin n_fail++; $display("FAIL mid_entries: got %0d want 0", got.size()); end
  endtask

  task automatic test_debounce;
    int lat = 0;
    button_db = 1'b1;
    tick(5);
    button_db = 1'b0;
    tick(30);
    n_tests++; if ({writing_db, valid_db} !== 2'b00) begin n_fail++; $display("FAIL db_glitch: got %b want 00", {writing_db, valid_db}); end
    button_db = 1'b1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick(1);
      if (writing_db === 1'b1) lat = c;
    end
    // key accepted 2+8 cycles after the edge, FSM registers it one cycle later
    n_tests++; if (lat != 11) begin n_fail++; $display("FAIL db_latency: got %0d want 11", lat); end
    if (lat != 0 && lat < 12) tick(12 - lat);
    button_db = 1'b0;
    tick(28);
    n_tests++; if ({valid_db, error_db, space_db, code_db} !== 13'h1002) begin
      n_fail++; $display("FAIL db_token: got %h want 1002", {valid_db, error_db, space_db, code_db});
    end
    n_tests++; if (overflow_db !== 1'b0) begin n_fail++; $display("FAIL db_overflow: got %b want 0", overflow_db); end
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_dash_dot();
    test_error();
    test_hold();
    test_random();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    test_debounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
